// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, N combinational read ports with
// write-to-read bypass, optional hardwired zero entry, per-entry busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  output logic [NUM_RD-1:0]        rbusy_o,
  input  logic [1:0]               wen_i,
  input  logic [2*ADDR_W-1:0]      waddr_i,
  input  logic [2*DATA_W-1:0]      wdata_i,
  input  logic                     alloc_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  output logic                     ready_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  idx_r, idx_s;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [DEPTH-1:0]   busy_r, busy_s;

  logic [ADDR_W-1:0]  wa0_s, wa1_s;
  logic [DATA_W-1:0]  wd0_s, wd1_s;
  logic               active_s, we0_s, we1_s, alloc_s;

  assign wa0_s = waddr_i[0 +: ADDR_W];
  assign wa1_s = waddr_i[ADDR_W +: ADDR_W];
  assign wd0_s = wdata_i[0 +: DATA_W];
  assign wd1_s = wdata_i[DATA_W +: DATA_W];

  // Everything observable or committed is held off while clearing or in reset.
  assign active_s = (state_r == READY) && !rst_i;
  assign ready_o  = active_s;
  assign we0_s    = active_s && wen_i[0] && !(HAS_ZERO && (wa0_s == ZERO_IDX));
  assign we1_s    = active_s && wen_i[1] && !(HAS_ZERO && (wa1_s == ZERO_IDX));
  assign alloc_s  = active_s && alloc_i && !(HAS_ZERO && (alloc_addr_i == ZERO_IDX));

  // Clear sequencer next-state logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      CLEAR: begin
        idx_s = idx_r + ONE_IDX;
        if (idx_r == LAST_IDX) begin
          state_s = READY;
        end else begin
          state_s = CLEAR;
        end
      end
      READY:   state_s = READY;
      default: state_s = CLEAR;
    endcase
  end

  // Sequencer state and clear index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= CLEAR;
      idx_r   <= ZERO_IDX;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  // Storage: clear one entry per cycle, then accept writes (port 1 lands last).
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_r == CLEAR)) begin
      mem_r[idx_r] <= {DATA_W{1'b0}};
    end else begin
      if (we0_s) mem_r[wa0_s] <= wd0_s;
      if (we1_s) mem_r[wa1_s] <= wd1_s;
    end
  end

  // Busy next-state: writes retire a producer, an allocation in the same cycle wins.
  always_comb begin
    busy_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      busy_s[i] = (busy_r[i] & ~((we0_s && (wa0_s == ADDR_W'(i))) ||
                                 (we1_s && (wa1_s == ADDR_W'(i))))) |
                  (alloc_s && (alloc_addr_i == ADDR_W'(i)));
    end
    busy_s[0] = busy_s[0] && !HAS_ZERO;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_s;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic              hit0_s, hit1_s, rb_s;
    logic [DATA_W-1:0] rd_s;

    assign ra_s   = raddr_i[k*ADDR_W +: ADDR_W];
    assign hit0_s = wen_i[0] && (wa0_s == ra_s);
    assign hit1_s = wen_i[1] && (wa1_s == ra_s);

    // Read mux with bypass; an in-flight write also hides the busy bit it retires.
    always_comb begin
      rd_s = {DATA_W{1'b0}};
      rb_s = 1'b0;
      if (!active_s) begin
        rd_s = {DATA_W{1'b0}};
        rb_s = 1'b0;
      end else if (HAS_ZERO && (ra_s == ZERO_IDX)) begin
        rd_s = {DATA_W{1'b0}};
        rb_s = 1'b0;
      end else begin
        if (hit1_s) begin
          rd_s = wd1_s;
        end else if (hit0_s) begin
          rd_s = wd0_s;
        end else begin
          rd_s = mem_r[ra_s];
        end
        rb_s = busy_r[ra_s] && !(hit0_s || hit1_s);
      end
    end

    assign rdata_o[k*DATA_W +: DATA_W] = rd_s;
    assign rbusy_o[k]                  = rb_s;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [1:0]       wen;
  logic [2*AW-1:0]  waddr;
  logic [2*DW-1:0]  wdata;
  logic             alloc;
  logic [AW-1:0]    alloc_addr;
  logic             ready;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .wen_i(wen), .waddr_i(waddr), .wdata_i(wdata), .alloc_i(alloc),
    .alloc_addr_i(alloc_addr), .ready_o(ready)
  );

  // sel: 0 ready, 1 rdata port0, 2 rdata port1, 3 rbusy port0, 4 rbusy port1
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] act;
  int          errors = 0;
  int          checks = 0;

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      case (cur.sel)
        0:       act = {31'd0, ready};
        1:       act = rdata[31:0];
        2:       act = rdata[63:32];
        3:       act = {31'd0, rbusy[0]};
        4:       act = {31'd0, rbusy[1]};
        default: act = 32'hxxxx_xxxx;
      endcase
      checks++;
      if (act !== cur.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", cur.name, act, cur.val, $time);
      end
    end
  end

  task automatic check_now(input string nm, input logic [31:0] got, input logic [31:0] v);
    checks++;
    if (got !== v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, v, $time);
    end
  endtask

  task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    wen        = 2'b00;
    waddr      = '0;
    wdata      = '0;
    alloc      = 1'b0;
    alloc_addr = 5'd0;
    raddr      = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int port, input logic [4:0] a);
    if (port == 0) raddr[4:0] = a;
    else           raddr[9:5] = a;
  endtask

  task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
    wen[port] = 1'b1;
    if (port == 0) begin
      waddr[4:0]   = a;
      wdata[31:0]  = d;
    end else begin
      waddr[9:5]   = a;
      wdata[63:32] = d;
    end
  endtask

  // Walks the 32 clear cycles following a reset release, then checks ready rises.
  task automatic clear_count(input bit try_lost);
    logic [4:0] a;
    for (int c = 0; c < 32; c++) begin
      a = c[4:0];
      rd(0, a);
      rd(1, 5'd31 - a);
      expect_v("clr_ready", 0, 32'd0);
      expect_v("clr_rdata0", 1, 32'd0);
      expect_v("clr_rbusy0", 3, 32'd0);
      if (try_lost && c == 5) wr(0, 5'd4, 32'h1234_5678);
      if (try_lost && c == 6) begin
        alloc      = 1'b1;
        alloc_addr = 5'd4;
      end
      next();
    end
    expect_v("ready_rise", 0, 32'd1);
  endtask

  initial begin
    logic [4:0] a;
    int         w;
    idle();
    rst = 1'b1;
    #1;
    check_now("rst_state_ready", {31'd0, ready}, 32'd0);
    check_now("rst_state_rdata", rdata[31:0], 32'd0);
    check_now("rst_state_rbusy", {30'd0, rbusy}, 32'd0);
    expect_v("rst_ready", 0, 32'd0);
    next();
    rst = 1'b0;
    clear_count(1'b1);

    // first READY cycle: lost write/alloc must not have landed
    rd(0, 5'd4);
    rd(1, 5'd0);
    expect_v("lost_write", 1, 32'd0);
    expect_v("lost_alloc", 3, 32'd0);
    expect_v("zero_rd", 2, 32'd0);
    next();
    for (int i = 0; i < 16; i++) begin
      a = 5'(2 * i);
      rd(0, a);
      rd(1, a + 5'd1);
      expect_v("cleared_p0", 1, 32'd0);
      expect_v("cleared_p1", 2, 32'd0);
      next();
    end

    // write with same-cycle bypass, then from storage
    wr(0, 5'd3, 32'hDEAD_BEEF);
    rd(0, 5'd3);
    rd(1, 5'd4);
    expect_v("bypass_p0", 1, 32'hDEAD_BEEF);
    expect_v("other_addr", 2, 32'd0);
    expect_v("ready_hi", 0, 32'd1);
    next();
    rd(0, 5'd3);
    expect_v("stored_3", 1, 32'hDEAD_BEEF);
    next();

    // dual-write collision: port 1 wins
    wr(0, 5'd7, 32'h0000_0011);
    wr(1, 5'd7, 32'h0000_0022);
    rd(0, 5'd7);
    rd(1, 5'd3);
    expect_v("collide_byp", 1, 32'h0000_0022);
    expect_v("collide_other", 2, 32'hDEAD_BEEF);
    next();
    rd(0, 5'd7);
    expect_v("collide_store", 1, 32'h0000_0022);
    next();

    // zero register ignores writes and allocs
    wr(0, 5'd0, 32'h0000_0055);
    alloc      = 1'b1;
    alloc_addr = 5'd0;
    rd(0, 5'd0);
    expect_v("zero_byp", 1, 32'd0);
    expect_v("zero_busy_now", 3, 32'd0);
    next();
    rd(0, 5'd0);
    expect_v("zero_store", 1, 32'd0);
    expect_v("zero_busy", 3, 32'd0);
    next();

    // scoreboard: alloc, hazard visible next cycle, write retires it
    alloc      = 1'b1;
    alloc_addr = 5'd9;
    rd(0, 5'd9);
    expect_v("alloc_same", 3, 32'd0);
    next();
    rd(0, 5'd9);
    rd(1, 5'd9);
    expect_v("busy_p0", 3, 32'd1);
    expect_v("busy_p1", 4, 32'd1);
    next();
    wr(1, 5'd9, 32'hCAFE_F00D);
    rd(0, 5'd9);
    expect_v("wr_mask_busy", 3, 32'd0);
    expect_v("wr_byp_9", 1, 32'hCAFE_F00D);
    next();
    rd(0, 5'd9);
    expect_v("busy_cleared", 3, 32'd0);
    expect_v("stored_9", 1, 32'hCAFE_F00D);
    next();
    alloc      = 1'b1;
    alloc_addr = 5'd9;
    wr(0, 5'd9, 32'hA5A5_A5A5);
    rd(0, 5'd9);
    expect_v("alloc_wr_same", 3, 32'd0);
    expect_v("alloc_wr_byp", 1, 32'hA5A5_A5A5);
    next();
    rd(0, 5'd9);
    expect_v("alloc_wins", 3, 32'd1);
    expect_v("alloc_wr_store", 1, 32'hA5A5_A5A5);
    next();

    // independent writes on both ports, each read port sees its own
    wr(0, 5'd12, 32'h0000_000C);
    wr(1, 5'd13, 32'h0000_000D);
    rd(0, 5'd12);
    rd(1, 5'd13);
    expect_v("dual_p0", 1, 32'h0000_000C);
    expect_v("dual_p1", 2, 32'h0000_000D);
    next();

    // reset from READY, then again mid-clear
    rst = 1'b1;
    rd(0, 5'd3);
    expect_v("rst2_ready", 0, 32'd0);
    expect_v("rst2_rdata", 1, 32'd0);
    next();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      expect_v("mid_ready", 0, 32'd0);
      next();
    end
    rst = 1'b1;
    expect_v("rst3_ready", 0, 32'd0);
    next();
    rst = 1'b0;
    clear_count(1'b0);

    rd(0, 5'd3);
    rd(1, 5'd7);
    expect_v("recl_3", 1, 32'd0);
    expect_v("recl_7", 2, 32'd0);
    next();
    rd(0, 5'd9);
    rd(1, 5'd12);
    expect_v("recl_busy9", 3, 32'd0);
    expect_v("recl_9", 1, 32'd0);
    expect_v("recl_12", 2, 32'd0);
    next();
    rd(0, 5'd13);
    expect_v("recl_13", 1, 32'd0);
    next();

    w = 0;
    while ((ready !== 1'b1) && (w < 40)) begin
      next();
      w++;
    end
    check_now("ready_wait_expired", {31'd0, ready}, 32'd1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the CPU datapath: configurable data width, depth and read-port count; two write ports; same-cycle write-to-read bypass; optional hardwired zero register; per-register busy scoreboard for hazard detection. After reset, a clear sequencer zeroes the array one entry per cycle before the file reports ready. It sits between the decode stage (reads, allocations) and the writeback stage (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (>=1)
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, never busy

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- raddr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rdata_o  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rbusy_o  out  NUM_RD  port k's register has a pending producer
- wen_i  in  2  write enables, ports 0 and 1
- waddr_i  in  2*ADDR_W  write addresses
- wdata_i  in  2*DATA_W  write data
- alloc_i  in  1  mark alloc_addr_i busy (producer issued)
- alloc_addr_i  in  ADDR_W  register to mark busy
- ready_o  out  1  clear sequence done; file accepts writes/allocs

## Operation
- FSM states: CLEAR, READY.
- rst_i=1: state <= CLEAR, clear index <= 0, all busy bits <= 0. Outputs during/after reset: ready_o=0, rdata_o=0, rbusy_o=0.
- CLEAR: each cycle writes 0 to entry[index], index++; after writing DEPTH-1, state <= READY. wen_i and alloc_i ignored. Reads return 0, rbusy_o=0.
- READY: ready_o=1.
  - Write: wen_i[p]=1 commits wdata p to waddr p at posedge. Both ports same address: port 1 wins. Write to entry 0 with ZERO_REG=1 discarded.
  - Write clears the busy bit of its address (either port).
  - alloc_i=1 sets busy[alloc_addr_i]. Alloc and write to the same address in one cycle: busy ends 1 (new producer wins). Alloc to entry 0 with ZERO_REG=1 ignored.
  - Read port k (combinational): ZERO_REG=1 and addr 0 -> 0; else if wen_i[1] and address match -> wdata 1; else if wen_i[0] and match -> wdata 0; else stored entry.
  - rbusy_o[k] = busy[addr] and not (any same-cycle write to addr); 0 for entry 0 when ZERO_REG=1. Same-cycle alloc does not affect rbusy_o until next cycle.
- Bypass and busy masking use only the defined write enables; no X-based qualification.
- Reset asserted in any state (including mid-CLEAR) restarts CLEAR at index 0.

## Timing
- Read latency 0 (combinational from raddr_i, wen_i, waddr_i, wdata_i).
- Write visible in storage from the cycle after the posedge; visible same cycle via bypass.
- Busy set/clear effective the cycle after the posedge of alloc/write.
- Clear duration: DEPTH cycles after the last cycle with rst_i=1; ready_o rises on cycle DEPTH (first cycle in READY).
- No handshake stalls: callers must hold writes/allocs until ready_o=1; anything presented earlier is dropped.

## Test plan
- Reset then count: rst_i 1 cycle, DEPTH=32 -> ready_o=0 for 32 cycles, 1 on cycle 32; all 32 entries read 0; write attempt at cycle 5 lost.
- Write/bypass: READY, wen_i=2'b01 addr 3 data 0xDEADBEEF, read port 0 addr 3 same cycle -> 0xDEADBEEF; next cycle no write -> still 0xDEADBEEF.
- Dual-write collision: both ports addr 7, data 0x11 (p0), 0x22 (p1) -> same-cycle read 0x22, stored 0x22.
- Zero register: write 0x55 to addr 0 -> reads 0 same and next cycle; alloc addr 0 -> rbusy_o stays 0.
- Scoreboard: alloc addr 9 -> next cycle rbusy_o=1; write addr 9 -> rbusy_o=0 that cycle with data bypassed; alloc+write addr 9 same cycle -> rbusy_o=1 next cycle.
- Reset mid-clear: rst_i at cycle 10 of CLEAR -> ready_o rises 32 cycles after second reset release; busy bits all 0.
